phv_field_writer: RTL and testbench
===================================

PHV_FIELD_WRITER -- requirements
Module: phv_field_writer

Interface
REQ-001 Parameter PHV_WIDTH, default 1024, sets the PHV width in bits.
REQ-002 Parameter INSERT_WIDTH, default 8, sets the field width in bits; N = PHV_WIDTH/INSERT_WIDTH slots.
REQ-003 Parameter OFFSET_WIDTH, default $clog2(PHV_WIDTH/INSERT_WIDTH), sets the slot-index width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 i_clk  in  1  clock; all flops rise-edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_phv_valid  in  1  base PHV offered.
REQ-008 i_phv  in  PHV_WIDTH  base PHV contents.
REQ-009 i_phv_bypass  in  1  qualifies i_phv_valid; PHV needs no field writes.
REQ-010 o_phv_ready  out  1  base PHV accepted this cycle when high with i_phv_valid.
REQ-011 i_field_valid  in  1  field write offered.
REQ-012 i_field_data  in  INSERT_WIDTH  field value.
REQ-013 i_field_offset  in  OFFSET_WIDTH  slot index; 0 = most-significant slot.
REQ-014 i_field_last  in  1  final field write for the current PHV.
REQ-015 o_field_ready  out  1  field write accepted when high with i_field_valid.
REQ-016 o_phv_valid  out  1  modified PHV available.
REQ-017 o_phv  out  PHV_WIDTH  modified PHV.
REQ-018 i_phv_ready  in  1  downstream accepts o_phv.
REQ-019 o_err_offset  out  1  one-cycle pulse on an accepted write with i_field_offset >= N.

Function
REQ-020 FSM states: IDLE, WRITE, OUTPUT; reset state IDLE.
REQ-021 IDLE: o_phv_ready=1, o_field_ready=0, o_phv_valid=0.
REQ-022 IDLE with i_phv_valid: load i_phv into the PHV register; next state OUTPUT if i_phv_bypass, else WRITE.
REQ-023 WRITE: o_field_ready=1, o_phv_ready=0; each accepted write replaces bits [(N-offset-1)*INSERT_WIDTH +: INSERT_WIDTH]; all other bits are held.
REQ-024 Slot mapping SHALL be the exact inverse of the team's field extractor: a field written at offset k reads back from the extractor at offset k.
REQ-025 Write with offset >= N: PHV unchanged, write consumed, o_err_offset pulses the next cycle.
REQ-026 Repeated writes to the same offset: last write wins.
REQ-027 Accepted write with i_field_last=1: write applied, next state OUTPUT; o_phv_valid rises exactly one cycle after that handshake.
REQ-028 OUTPUT: o_phv_valid=1, o_phv = PHV register, held stable until i_phv_ready; o_phv_ready=0, o_field_ready=0.
REQ-029 OUTPUT with i_phv_ready: next state IDLE; throughput is at most one PHV per (fields+2) cycles.
REQ-030 i_field_valid in IDLE/OUTPUT and i_phv_valid in WRITE/OUTPUT SHALL be ignored (not consumed).
REQ-031 o_phv SHALL be driven directly from the register (no combinational input-to-output path).

Reset
REQ-032 On i_rst_n low, asynchronously: state IDLE, PHV register 0, o_phv_valid 0, o_err_offset 0, o_phv 0.
REQ-033 Reset mid-WRITE or mid-OUTPUT SHALL discard the in-flight PHV with no output emitted.

Configuration
REQ-034 Macro PHV_FIELD_WRITER_CNT_EN defined: add output o_wr_cnt (OFFSET_WIDTH+1 bits) = count of in-range writes applied to the current PHV, cleared on base-PHV load, saturating at all-ones, valid while o_phv_valid.
REQ-035 Macro undefined: port o_wr_cnt and its logic are absent; all other behaviour is identical.

Verification
REQ-036 Load i_phv=0, writes (0,0xAA),(127,0x55,last) -> o_phv[1023:1016]=0xAA, o_phv[7:0]=0x55, rest 0; o_phv_valid one cycle after last.
REQ-037 i_phv=all-ones with i_phv_bypass=1 -> o_phv_valid next cycle, o_phv all-ones, no field handshake.
REQ-038 Writes (5,0x11),(5,0x22,last) -> slot 5 = 0x22; with CNT_EN, o_wr_cnt=2.
REQ-039 Hold i_phv_ready=0 for 10 cycles in OUTPUT, toggling i_phv_valid/i_field_valid -> o_phv stable, nothing consumed; PHV leaves on the first i_phv_ready=1.
REQ-040 PHV_WIDTH=96, INSERT_WIDTH=8, write offset 12 -> PHV unchanged, o_err_offset one pulse.
REQ-041 Assert i_rst_n low after 3 of 5 writes -> outputs 0, state IDLE; next PHV processes cleanly with no residue.

Source files
------------

// File: rtl/phv_field_writer.sv
// PHV field writer: loads a base PHV, applies slot-indexed field writes, then presents the result.
// Optional write counter output o_wr_cnt is enabled with macro PHV_FIELD_WRITER_CNT_EN.
module phv_field_writer #(
   parameter int PHV_WIDTH    = 1024,
   parameter int INSERT_WIDTH = 8,
   parameter int OFFSET_WIDTH = $clog2(PHV_WIDTH / INSERT_WIDTH)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_phv_valid,
   input  logic [PHV_WIDTH-1:0]    i_phv,
   input  logic                    i_phv_bypass,
   output logic                    o_phv_ready,
   input  logic                    i_field_valid,
   input  logic [INSERT_WIDTH-1:0] i_field_data,
   input  logic [OFFSET_WIDTH-1:0] i_field_offset,
   input  logic                    i_field_last,
   output logic                    o_field_ready,
   output logic                    o_phv_valid,
   output logic [PHV_WIDTH-1:0]    o_phv,
   input  logic                    i_phv_ready,
`ifdef PHV_FIELD_WRITER_CNT_EN
   output logic [OFFSET_WIDTH:0]   o_wr_cnt,
`endif
   output logic                    o_err_offset
);

   localparam int NUM_SLOTS = PHV_WIDTH / INSERT_WIDTH;
   localparam logic [OFFSET_WIDTH:0] SLOT_LIMIT = (OFFSET_WIDTH + 1)'(NUM_SLOTS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   state_t                 state_r;
   logic [PHV_WIDTH-1:0]   phv_r;
   logic                   phv_ready_r;
   logic                   field_ready_r;
   logic                   phv_valid_r;
   logic                   err_r;
   logic                   in_range_s;

   // Offsets are unsigned; anything at or beyond the slot count is an error write.
   assign in_range_s = ({1'b0, i_field_offset} < SLOT_LIMIT);

`ifdef PHV_FIELD_WRITER_CNT_EN
   localparam logic [OFFSET_WIDTH:0] CNT_ONE = {{OFFSET_WIDTH{1'b0}}, 1'b1};
   logic [OFFSET_WIDTH:0] cnt_r;

   // Count in-range writes on the current PHV, saturating at all-ones.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_r <= '0;
      end else if (state_r == IDLE && i_phv_valid) begin
         cnt_r <= '0;
      end else if (state_r == WRITE && i_field_valid && in_range_s && cnt_r != '1) begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   assign o_wr_cnt = cnt_r;
`endif

   // Control FSM with registered handshake flags and the PHV register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r       <= IDLE;
         phv_r         <= '0;
         phv_ready_r   <= 1'b1;
         field_ready_r <= 1'b0;
         phv_valid_r   <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (i_phv_valid) begin
                  phv_r       <= i_phv;
                  phv_ready_r <= 1'b0;
                  if (i_phv_bypass) begin
                     state_r     <= OUTPUT;
                     phv_valid_r <= 1'b1;
                  end else begin
                     state_r       <= WRITE;
                     field_ready_r <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (i_field_valid) begin
                  // Slot 0 is the most-significant field of the PHV.
                  for (int s = 0; s < NUM_SLOTS; s++) begin
                     if (i_field_offset == OFFSET_WIDTH'(s)) begin
                        phv_r[(NUM_SLOTS-1-s)*INSERT_WIDTH +: INSERT_WIDTH] <= i_field_data;
                     end
                  end
                  err_r <= ~in_range_s;
                  if (i_field_last) begin
                     state_r       <= OUTPUT;
                     field_ready_r <= 1'b0;
                     phv_valid_r   <= 1'b1;
                  end
               end
            end
            OUTPUT: begin
               if (i_phv_ready) begin
                  state_r     <= IDLE;
                  phv_valid_r <= 1'b0;
                  phv_ready_r <= 1'b1;
               end
            end
            default: begin
               state_r       <= IDLE;
               phv_ready_r   <= 1'b1;
               field_ready_r <= 1'b0;
               phv_valid_r   <= 1'b0;
            end
         endcase
      end
   end

   assign o_phv         = phv_r;
   assign o_phv_ready   = phv_ready_r;
   assign o_field_ready = field_ready_r;
   assign o_phv_valid   = phv_valid_r;
   assign o_err_offset  = err_r;

endmodule

// File: tb/tb_phv_field_writer.sv
// Directed self-checking bench for phv_field_writer: default 1024-bit instance plus a 96-bit instance.
module tb_phv_field_writer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Main (1024-bit) instance signals.
   logic          phv_valid = 1'b0;
   logic [1023:0] phv_in = '0;
   logic          bypass = 1'b0;
   logic          phv_ready;
   logic          field_valid = 1'b0;
   logic [7:0]    field_data = '0;
   logic [6:0]    field_offset = '0;
   logic          field_last = 1'b0;
   logic          field_ready;
   logic          out_valid;
   logic [1023:0] out_phv;
   logic          out_ready = 1'b0;
   logic          err;
`ifdef PHV_FIELD_WRITER_CNT_EN
   logic [7:0]    wr_cnt;
`endif

   // Small (96-bit, 12 slots) instance signals.
   logic          s_phv_valid = 1'b0;
   logic [95:0]   s_phv_in = '0;
   logic          s_phv_ready;
   logic          s_field_valid = 1'b0;
   logic [7:0]    s_field_data = '0;
   logic [3:0]    s_field_offset = '0;
   logic          s_field_last = 1'b0;
   logic          s_field_ready;
   logic          s_out_valid;
   logic [95:0]   s_out_phv;
   logic          s_err;
`ifdef PHV_FIELD_WRITER_CNT_EN
   logic [4:0]    s_wr_cnt;
`endif

   logic [1023:0] exp_phv;
   logic [1023:0] ones_phv;

   phv_field_writer dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_phv_valid(phv_valid), .i_phv(phv_in), .i_phv_bypass(bypass), .o_phv_ready(phv_ready),
      .i_field_valid(field_valid), .i_field_data(field_data), .i_field_offset(field_offset),
      .i_field_last(field_last), .o_field_ready(field_ready),
      .o_phv_valid(out_valid), .o_phv(out_phv), .i_phv_ready(out_ready),
`ifdef PHV_FIELD_WRITER_CNT_EN
      .o_wr_cnt(wr_cnt),
`endif
      .o_err_offset(err)
   );

   phv_field_writer #(.PHV_WIDTH(96), .INSERT_WIDTH(8)) dut_s (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_phv_valid(s_phv_valid), .i_phv(s_phv_in), .i_phv_bypass(1'b0), .o_phv_ready(s_phv_ready),
      .i_field_valid(s_field_valid), .i_field_data(s_field_data), .i_field_offset(s_field_offset),
      .i_field_last(s_field_last), .o_field_ready(s_field_ready),
      .o_phv_valid(s_out_valid), .o_phv(s_out_phv), .i_phv_ready(1'b1),
`ifdef PHV_FIELD_WRITER_CNT_EN
      .o_wr_cnt(s_wr_cnt),
`endif
      .o_err_offset(s_err)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1023:0] base, input logic byp);
      phv_valid = 1'b1;
      phv_in    = base;
      bypass    = byp;
      step();
      phv_valid = 1'b0;
      bypass    = 1'b0;
   endtask

   task automatic wr(input logic [6:0] off, input logic [7:0] data, input logic last);
      field_valid  = 1'b1;
      field_offset = off;
      field_data   = data;
      field_last   = last;
      step();
      field_valid = 1'b0;
      field_last  = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      ones_phv = '1;

      // Reset state.
      #12;
      chk("rst_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_phv_zero", 128'(out_phv == '0), 128'(1'b1));
      chk("rst_phv_ready", 128'(phv_ready), 128'(1'b1));
      chk("rst_field_ready", 128'(field_ready), 128'(1'b0));
      chk("rst_err", 128'(err), 128'(1'b0));
      rst_n = 1'b1;
      step();

      // First and last slots on a zero base.
      load('0, 1'b0);
      chk("w1_field_ready", 128'(field_ready), 128'(1'b1));
      chk("w1_phv_ready", 128'(phv_ready), 128'(1'b0));
      wr(7'd0, 8'hAA, 1'b0);
      chk("w1_no_valid_mid", 128'(out_valid), 128'(1'b0));
      wr(7'd127, 8'h55, 1'b1);
      chk("w1_valid", 128'(out_valid), 128'(1'b1));
      chk("w1_top", 128'(out_phv[1023:1016]), 128'(8'hAA));
      chk("w1_bot", 128'(out_phv[7:0]), 128'(8'h55));
      chk("w1_rest", 128'(out_phv[1015:8] == '0), 128'(1'b1));
      chk("w1_err", 128'(err), 128'(1'b0));
`ifdef PHV_FIELD_WRITER_CNT_EN
      chk("w1_cnt", 128'(wr_cnt), 128'(8'd2));
`endif
      drain();
      chk("w1_drained", 128'(out_valid), 128'(1'b0));
      chk("w1_idle_ready", 128'(phv_ready), 128'(1'b1));

      // Bypass path then backpressure with ignored inputs.
      load(ones_phv, 1'b1);
      chk("byp_valid", 128'(out_valid), 128'(1'b1));
      chk("byp_phv", 128'(out_phv == ones_phv), 128'(1'b1));
      chk("byp_field_ready", 128'(field_ready), 128'(1'b0));
`ifdef PHV_FIELD_WRITER_CNT_EN
      chk("byp_cnt", 128'(wr_cnt), 128'(8'd0));
`endif
      phv_in = '0;
      for (int i = 0; i < 10; i++) begin
         phv_valid    = i[0];
         field_valid  = ~i[0];
         field_offset = 7'd3;
         field_data   = 8'h00;
         step();
         chk("hold_phv", 128'(out_phv == ones_phv), 128'(1'b1));
         chk("hold_valid", 128'(out_valid), 128'(1'b1));
         chk("hold_ready", 128'(phv_ready | field_ready), 128'(1'b0));
      end
      phv_valid   = 1'b0;
      field_valid = 1'b0;
      drain();
      chk("hold_release", 128'(out_valid), 128'(1'b0));

      // Field write in IDLE is ignored, then last-write-wins on slot 5.
      field_valid  = 1'b1;
      field_offset = 7'd5;
      field_data   = 8'hEE;
      field_last   = 1'b1;
      step();
      field_valid = 1'b0;
      field_last  = 1'b0;
      chk("idle_field_ignored", 128'(out_valid), 128'(1'b0));
      chk("idle_still_ready", 128'(phv_ready), 128'(1'b1));
      load('0, 1'b0);
      wr(7'd5, 8'h11, 1'b0);
      wr(7'd5, 8'h22, 1'b1);
      exp_phv = '0;
      exp_phv[983:976] = 8'h22;
      chk("lww_slot5", 128'(out_phv[983:976]), 128'(8'h22));
      chk("lww_whole", 128'(out_phv == exp_phv), 128'(1'b1));
`ifdef PHV_FIELD_WRITER_CNT_EN
      chk("lww_cnt", 128'(wr_cnt), 128'(8'd2));
`endif
      drain();

      // Reset after 3 of 5 writes, then a clean PHV.
      load({128{8'hC3}}, 1'b0);
      wr(7'd10, 8'h01, 1'b0);
      wr(7'd20, 8'h02, 1'b0);
      wr(7'd30, 8'h03, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_phv", 128'(out_phv == '0), 128'(1'b1));
      chk("mid_rst_valid", 128'(out_valid), 128'(1'b0));
      chk("mid_rst_field_ready", 128'(field_ready), 128'(1'b0));
      chk("mid_rst_phv_ready", 128'(phv_ready), 128'(1'b1));
      rst_n = 1'b1;
      step();
      chk("post_rst_idle_valid", 128'(out_valid), 128'(1'b0));
      load('0, 1'b0);
      wr(7'd1, 8'h77, 1'b1);
      exp_phv = '0;
      exp_phv[1015:1008] = 8'h77;
      chk("post_rst_valid", 128'(out_valid), 128'(1'b1));
      chk("post_rst_phv", 128'(out_phv == exp_phv), 128'(1'b1));
`ifdef PHV_FIELD_WRITER_CNT_EN
      chk("post_rst_cnt", 128'(wr_cnt), 128'(8'd1));
`endif
      drain();

      // Out-of-range offset on the 12-slot instance.
      s_phv_valid = 1'b1;
      s_phv_in    = 96'h0123_4567_89AB_CDEF_0123_4567;
      step();
      s_phv_valid = 1'b0;
      chk("s_field_ready", 128'(s_field_ready), 128'(1'b1));
      chk("s_err_idle", 128'(s_err), 128'(1'b0));
      s_field_valid  = 1'b1;
      s_field_offset = 4'd12;
      s_field_data   = 8'hFF;
      step();
      chk("s_err_pulse", 128'(s_err), 128'(1'b1));
      chk("s_phv_kept", 128'(s_out_phv), 128'(96'h0123_4567_89AB_CDEF_0123_4567));
      s_field_offset = 4'd11;
      s_field_data   = 8'h5A;
      s_field_last   = 1'b1;
      step();
      s_field_valid = 1'b0;
      s_field_last  = 1'b0;
      chk("s_err_single", 128'(s_err), 128'(1'b0));
      chk("s_valid", 128'(s_out_valid), 128'(1'b1));
      chk("s_phv", 128'(s_out_phv), 128'(96'h0123_4567_89AB_CDEF_0123_455A));
`ifdef PHV_FIELD_WRITER_CNT_EN
      chk("s_cnt", 128'(s_wr_cnt), 128'(5'd1));
`endif
      step();
      chk("s_drained", 128'(s_out_valid), 128'(1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
